// File: rtl/ttt_game_ctrl.sv
// Tic-tac-toe game controller: edge-detected buttons drive a one-hot cursor,
// X/O occupancy, turn tracking and win/draw detection for the grid display.
module ttt_game_ctrl #(
    parameter int unsigned FIRST_PLAYER = 0,
    parameter int unsigned CURSOR_HOME  = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_enter,
    input  logic       btn_start,
    output logic [8:0] cursor,
    output logic [8:0] board_x,
    output logic [8:0] board_o,
    output logic       turn_o,
    output logic       playing,
    output logic       game_over,
    output logic [1:0] winner
);

    localparam int unsigned N_CELLS = 9;
    localparam int unsigned N_LINES = 8;
    localparam int unsigned N_BTNS  = 4;

    localparam logic [N_CELLS-1:0] HOME_ONEHOT = N_CELLS'(1) << CURSOR_HOME;
    localparam logic               FIRST_TURN  = 1'(FIRST_PLAYER);
    localparam logic [N_CELLS-1:0] FULL_BOARD  = 9'h1FF;

    // Rows, columns, then the two diagonals (cell index = y*3+x).
    localparam logic [N_CELLS-1:0] WIN_LINES [N_LINES] = '{
        9'h007, 9'h038, 9'h1C0,
        9'h049, 9'h092, 9'h124,
        9'h111, 9'h054
    };

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PLAY  = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [N_BTNS-1:0]  prev_q, prev_d;
    logic [N_CELLS-1:0] cursor_q, cursor_d;
    logic [N_CELLS-1:0] board_x_q, board_x_d;
    logic [N_CELLS-1:0] board_o_q, board_o_d;
    logic               turn_q, turn_d;
    logic               playing_q, playing_d;
    logic               game_over_q, game_over_d;
    logic [1:0]         winner_q, winner_d;

    logic [N_BTNS-1:0]  btn_now;
    logic [N_BTNS-1:0]  ev;
    logic               ev_left, ev_right, ev_enter, ev_start;
    logic [N_CELLS-1:0] mover;
    logic               line_done;
    logic               cell_free;
    logic               do_start;

    assign btn_now  = {btn_start, btn_enter, btn_right, btn_left};
    assign ev       = btn_now & ~prev_q;
    assign ev_left  = ev[0];
    assign ev_right = ev[1];
    assign ev_enter = ev[2];
    assign ev_start = ev[3];

    // Line detection only for the side that has just placed a mark.
    always_comb begin
        mover     = turn_q ? board_o_q : board_x_q;
        line_done = 1'b0;
        for (int i = 0; i < int'(N_LINES); i++) begin
            if ((mover & WIN_LINES[i]) == WIN_LINES[i]) begin
                line_done = 1'b1;
            end
        end
    end

    assign cell_free = ((board_x_q | board_o_q) & cursor_q) == '0;

    always_comb begin
        state_d     = state_q;
        prev_d      = btn_now;
        cursor_d    = cursor_q;
        board_x_d   = board_x_q;
        board_o_d   = board_o_q;
        turn_d      = turn_q;
        winner_d    = winner_q;
        do_start    = 1'b0;
        playing_d   = 1'b0;
        game_over_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                do_start = ev_start;
            end
            ST_PLAY: begin
                if (ev_start) begin
                    do_start = 1'b1;
                end else if (ev_enter) begin
                    // Enter wins over any coincident move, even on an occupied cell.
                    if (cell_free) begin
                        if (turn_q) begin
                            board_o_d = board_o_q | cursor_q;
                        end else begin
                            board_x_d = board_x_q | cursor_q;
                        end
                        state_d = ST_CHECK;
                    end
                end else if (ev_right && !ev_left) begin
                    cursor_d = {cursor_q[N_CELLS-2:0], cursor_q[N_CELLS-1]};
                end else if (ev_left && !ev_right) begin
                    cursor_d = {cursor_q[0], cursor_q[N_CELLS-1:1]};
                end
            end
            ST_CHECK: begin
                if (line_done) begin
                    winner_d = turn_q ? 2'b10 : 2'b01;
                    state_d  = ST_DONE;
                end else if ((board_x_q | board_o_q) == FULL_BOARD) begin
                    winner_d = 2'b11;
                    state_d  = ST_DONE;
                end else begin
                    turn_d  = ~turn_q;
                    state_d = ST_PLAY;
                end
            end
            ST_DONE: begin
                do_start = ev_start;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (do_start) begin
            state_d   = ST_PLAY;
            cursor_d  = HOME_ONEHOT;
            board_x_d = '0;
            board_o_d = '0;
            turn_d    = FIRST_TURN;
            winner_d  = 2'b00;
        end

        playing_d   = (state_d == ST_PLAY) || (state_d == ST_CHECK);
        game_over_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            prev_q      <= '0;
            cursor_q    <= HOME_ONEHOT;
            board_x_q   <= '0;
            board_o_q   <= '0;
            turn_q      <= FIRST_TURN;
            playing_q   <= 1'b0;
            game_over_q <= 1'b0;
            winner_q    <= 2'b00;
        end else begin
            state_q     <= state_d;
            prev_q      <= prev_d;
            cursor_q    <= cursor_d;
            board_x_q   <= board_x_d;
            board_o_q   <= board_o_d;
            turn_q      <= turn_d;
            playing_q   <= playing_d;
            game_over_q <= game_over_d;
            winner_q    <= winner_d;
        end
    end

    assign cursor    = cursor_q;
    assign board_x   = board_x_q;
    assign board_o   = board_o_q;
    assign turn_o    = turn_q;
    assign playing   = playing_q;
    assign game_over = game_over_q;
    assign winner    = winner_q;

endmodule
